// File: rtl/pipe_pkg.sv
// Shared pipeline-register defaults: standard widths and the core's control-vector layout.
// ID/EX, EX/MEM and MEM/WB instances take their kill masks from here.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 5;
  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  // Control vector layout: WB in the low bits, then M, then EX.
  localparam int unsigned CTRL_WB_LSB = 0;
  localparam int unsigned CTRL_M_LSB  = 2;
  localparam int unsigned CTRL_EX_LSB = 5;

  localparam logic [CTRL_W_DEF-1:0] CTRL_WB_MASK = 8'b0000_0011;
  localparam logic [CTRL_W_DEF-1:0] CTRL_M_MASK  = 8'b0001_1100;
  localparam logic [CTRL_W_DEF-1:0] CTRL_EX_MASK = 8'b1110_0000;

  // Each stage only kills the control fields still ahead of it.
  localparam logic [CTRL_W_DEF-1:0] KILL_MASK_ID_EX  = CTRL_WB_MASK | CTRL_M_MASK | CTRL_EX_MASK;
  localparam logic [CTRL_W_DEF-1:0] KILL_MASK_EX_MEM = CTRL_WB_MASK | CTRL_M_MASK;
  localparam logic [CTRL_W_DEF-1:0] KILL_MASK_MEM_WB = CTRL_WB_MASK;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear, clocked on the selected capture edge.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter bit          NEG_EDGE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear beats increment; all-ones is sticky.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end
    end else begin : g_pos
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with stall hold, bubble/flush control kill,
// a valid bit and saturating stall/bubble/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W         = DATA_W_DEF,
  parameter int unsigned        NUM_DATA       = 3,
  parameter int unsigned        REG_W          = REG_W_DEF,
  parameter int unsigned        NUM_REG        = 4,
  parameter int unsigned        CTRL_W         = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0]  CTRL_KILL_MASK = CTRL_W'(KILL_MASK_ID_EX),
  parameter bit                 NEG_EDGE       = 1'b1,
  parameter int unsigned        CNT_W          = CNT_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       stall_i,
  input  logic                       bubble_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [NUM_REG*REG_W-1:0]   reg_i,
  input  logic [NUM_DATA*DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0]          ctrl_i,
  input  logic                       clr_cnt_i,
  output logic [NUM_REG*REG_W-1:0]   reg_o,
  output logic [NUM_DATA*DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic                       valid_o,
  output logic [CNT_W-1:0]           stall_cnt_o,
  output logic [CNT_W-1:0]           bubble_cnt_o,
  output logic [CNT_W-1:0]           flush_cnt_o
);

  generate
    if ((NUM_DATA < 1) || (NUM_REG < 1) || (CTRL_W < 1)) begin : g_bad_width
      $error("pipe_stage_reg: NUM_DATA, NUM_REG and CTRL_W must be at least 1");
    end
  endgenerate

  logic [NUM_REG*REG_W-1:0]   reg_q,   reg_d;
  logic [NUM_DATA*DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0]          ctrl_q,  ctrl_d;
  logic                       valid_q, valid_d;
  logic                       stall_ev, bubble_ev, kill;

  // Priority flush > stall > bubble > load; bubble and flush share the same datapath effect.
  always_comb begin
    stall_ev  = stall_i & ~flush_i;
    bubble_ev = bubble_i & ~stall_i & ~flush_i;
    kill      = flush_i | bubble_ev;
    reg_d     = reg_q;
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    if (!stall_ev) begin
      reg_d   = reg_i;
      data_d  = data_i;
      ctrl_d  = kill ? (ctrl_i & ~CTRL_KILL_MASK) : ctrl_i;
      valid_d = kill ? 1'b0 : valid_i;
    end
  end

  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          reg_q   <= '0;
          data_q  <= '0;
          ctrl_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          reg_q   <= reg_d;
          data_q  <= data_d;
          ctrl_q  <= ctrl_d;
          valid_q <= valid_d;
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          reg_q   <= '0;
          data_q  <= '0;
          ctrl_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          reg_q   <= reg_d;
          data_q  <= data_d;
          ctrl_q  <= ctrl_d;
          valid_q <= valid_d;
        end
      end
    end
  endgenerate

  assign reg_o   = reg_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;
  assign valid_o = valid_q;

  pipe_sat_counter #(.CNT_W(CNT_W), .NEG_EDGE(NEG_EDGE)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (stall_ev),
    .clr_i   (clr_cnt_i),
    .cnt_o   (stall_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W), .NEG_EDGE(NEG_EDGE)) u_bubble_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (bubble_ev),
    .clr_i   (clr_cnt_i),
    .cnt_o   (bubble_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W), .NEG_EDGE(NEG_EDGE)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (flush_i),
    .clr_i   (clr_cnt_i),
    .cnt_o   (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (falling-edge capture, 4-bit counters, kill mask 8'h0F).
module tb_pipe_stage_reg;

  localparam int unsigned DW   = 32;
  localparam int unsigned ND   = 3;
  localparam int unsigned RW   = 5;
  localparam int unsigned NR   = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned CNTW = 4;
  localparam logic [CW-1:0] KMASK = 8'h0F;

  typedef struct packed {
    logic [NR*RW-1:0] r;
    logic [ND*DW-1:0] d;
    logic [CW-1:0]    c;
    logic             v;
    logic [CNTW-1:0]  sc;
    logic [CNTW-1:0]  bc;
    logic [CNTW-1:0]  fc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, bubble, flush, valid, clr;
  logic [NR*RW-1:0]  reg_in;
  logic [ND*DW-1:0]  data_in;
  logic [CW-1:0]     ctrl_in;
  logic [NR*RW-1:0]  reg_out;
  logic [ND*DW-1:0]  data_out;
  logic [CW-1:0]     ctrl_out;
  logic              valid_out;
  logic [CNTW-1:0]   stall_cnt, bubble_cnt, flush_cnt;

  exp_t sb_q[$];
  exp_t m;
  exp_t last;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(DW), .NUM_DATA(ND), .REG_W(RW), .NUM_REG(NR), .CTRL_W(CW),
    .CTRL_KILL_MASK(KMASK), .NEG_EDGE(1'b1), .CNT_W(CNTW)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .stall_i      (stall),
    .bubble_i     (bubble),
    .flush_i      (flush),
    .valid_i      (valid),
    .reg_i        (reg_in),
    .data_i       (data_in),
    .ctrl_i       (ctrl_in),
    .clr_cnt_i    (clr),
    .reg_o        (reg_out),
    .data_o       (data_out),
    .ctrl_o       (ctrl_out),
    .valid_o      (valid_out),
    .stall_cnt_o  (stall_cnt),
    .bubble_cnt_o (bubble_cnt),
    .flush_cnt_o  (flush_cnt)
  );

  task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNTW-1:0] sat(input logic [CNTW-1:0] c, input logic inc, input logic cl);
    if (cl) return '0;
    if (inc && (c != {CNTW{1'b1}})) return c + CNTW'(1);
    return c;
  endfunction

  // Drive one edge's inputs just after the rising edge and queue the expected result.
  task automatic drive(input logic fl, input logic st, input logic bu, input logic va,
                       input logic [NR*RW-1:0] r, input logic [ND*DW-1:0] d,
                       input logic [CW-1:0] c, input logic cl);
    logic hold, bub;
    @(posedge clk);
    #1;
    flush = fl; stall = st; bubble = bu; valid = va;
    reg_in = r; data_in = d; ctrl_in = c; clr = cl;
    hold = st & ~fl;
    bub  = bu & ~st & ~fl;
    if (!hold) begin
      m.r = r;
      m.d = d;
      m.c = (fl | bub) ? (c & ~KMASK) : c;
      m.v = (fl | bub) ? 1'b0 : va;
    end
    m.sc = sat(m.sc, hold, cl);
    m.bc = sat(m.bc, bub, cl);
    m.fc = sat(m.fc, fl, cl);
    sb_q.push_back(m);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    @(negedge clk);
    #1;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
      return;
    end
    n_chk--;
    e = sb_q.pop_front();
    last = e;
    cmp({tag, ".reg"},   128'(reg_out),    128'(e.r));
    cmp({tag, ".data"},  128'(data_out),   128'(e.d));
    cmp({tag, ".ctrl"},  128'(ctrl_out),   128'(e.c));
    cmp({tag, ".valid"}, 128'(valid_out),  128'(e.v));
    cmp({tag, ".scnt"},  128'(stall_cnt),  128'(e.sc));
    cmp({tag, ".bcnt"},  128'(bubble_cnt), 128'(e.bc));
    cmp({tag, ".fcnt"},  128'(flush_cnt),  128'(e.fc));
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".reg"},   128'(reg_out),    128'(0));
    cmp({tag, ".data"},  128'(data_out),   128'(0));
    cmp({tag, ".ctrl"},  128'(ctrl_out),   128'(0));
    cmp({tag, ".valid"}, 128'(valid_out),  128'(0));
    cmp({tag, ".scnt"},  128'(stall_cnt),  128'(0));
    cmp({tag, ".bcnt"},  128'(bubble_cnt), 128'(0));
    cmp({tag, ".fcnt"},  128'(flush_cnt),  128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NR*RW-1:0] r1, r2;
    logic [ND*DW-1:0] d1, d2;
    r1 = {5'd3, 5'd2, 5'd1, 5'd9};
    r2 = {5'd30, 5'd17, 5'd4, 5'd22};
    d1 = {32'h5555_AAAA, 32'h0BAD_F00D, 32'h1234_5678};
    d2 = {32'hCAFE_0001, 32'h0000_FFFF, 32'hDEAD_BEEF};
    m  = '0;
    rst_n = 1'b0; stall = 0; bubble = 0; flush = 0; valid = 0; clr = 0;
    reg_in = '0; data_in = '0; ctrl_in = '0;

    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(0, 0, 0, 1, r1, d1, 8'hA5, 0);
    check_out("load");
    @(posedge clk);
    #1;
    cmp("rise_hold.data",  128'(data_out),  128'(last.d));
    cmp("rise_hold.ctrl",  128'(ctrl_out),  128'(last.c));
    cmp("rise_hold.valid", 128'(valid_out), 128'(last.v));

    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, r2, d2, 8'h11, 0);
      check_out("stall");
    end

    drive(0, 0, 1, 1, r2, d2, 8'hFF, 0);
    check_out("bubble");
    drive(1, 1, 0, 1, r1, d1, 8'h5A, 0);
    check_out("flush_over_stall");
    drive(0, 0, 0, 1, r2, d2, 8'h3C, 0);
    check_out("load2");
    drive(0, 0, 1, 0, r1, d1, 8'h3C, 0);
    check_out("bubble_noval");

    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 1, r2, d2, 8'h77, 0);
      check_out("stall_sat");
    end
    drive(0, 1, 0, 1, r2, d2, 8'h77, 1);
    check_out("clr_vs_stall");
    drive(0, 1, 0, 1, r2, d2, 8'h77, 0);
    check_out("stall_after_clr");

    // Reset dropped between edges while stalled must clear everything at once.
    @(posedge clk);
    #1;
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    m = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall = 1'b0;

    drive(0, 0, 0, 1, r1, d2, 8'hC3, 0);
    check_out("post_reset");
    drive(1, 0, 1, 1, r2, d1, 8'hF0, 0);
    check_out("flush_over_bubble");

    n_chk++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain observed=%0d expected=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
